ads127l01_fsync_rx: RTL and testbench
=====================================

ADS127L01_FSYNC_RX -- requirements
Module: ads127l01_fsync_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 24: ADC sample width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sck/dout/fsync, legal range 2..4.
REQ-003 SHALL have port aclk  input  1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port areset  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1: receiver enable; when low, frames are ignored.
REQ-006 SHALL have port sck  input  1: ADC serial clock, asynchronous to aclk.
REQ-007 SHALL have port dout  input  1: ADC serial data, MSB first.
REQ-008 SHALL have port fsync  input  1: ADC frame sync (master mode).
REQ-009 SHALL have port m_axis_tdata  output  32: sample, sign-extended from DATA_W.
REQ-010 SHALL have port m_axis_tvalid  output  1: sample valid.
REQ-011 SHALL have port m_axis_tready  input  1: downstream ready.
REQ-012 SHALL have port m_axis_tuser  output  1: CRC error flag for the presented sample (0 when CRC is compiled out).
REQ-013 SHALL have port overrun_cnt  output  16: saturating count of dropped samples.
REQ-014 SHALL have port frame_err  output  1: one-cycle pulse on an aborted short frame.

Function
REQ-015 SHALL pass sck, dout and fsync through SYNC_STAGES flops; sck rising edge detected from the last two synchronized stages; sck frequency <= aclk/4.
REQ-016 SHALL sample synchronized dout and fsync only on a detected sck rising edge.
REQ-017 SHALL detect frame start at an sck rising edge where fsync=1 and fsync was 0 at the previous sck rising edge; that same edge captures the MSB.
REQ-018 SHALL use FSM states IDLE, SHIFT, PUSH: IDLE->SHIFT on frame start with en=1; SHIFT->PUSH after FRAME_BITS bits are captured; PUSH->IDLE in the next cycle.
REQ-019 SHALL set FRAME_BITS=DATA_W, or DATA_W+8 when CRC is enabled.
REQ-020 SHALL, on a frame start during SHIFT, discard the partial word, pulse frame_err for one cycle, and restart SHIFT with the new MSB.
REQ-021 SHALL, in PUSH, load m_axis_tdata={{(32-DATA_W){w[DATA_W-1]}},w} and assert m_axis_tvalid; the output is therefore valid 2 aclk cycles after the sck edge of the last bit.
REQ-022 SHALL hold tdata, tuser and tvalid stable until tvalid&&tready; tvalid deasserts in the cycle after the handshake unless a new PUSH occurs in that cycle, in which case the new word is loaded and tvalid stays high.
REQ-023 SHALL, in PUSH while tvalid=1 and tready=0, drop the new word, keep the old word, and increment overrun_cnt saturating at 16'hFFFF.
REQ-024 SHALL, when en falls, return to IDLE within one cycle and abandon any partial word; an already-presented word stays valid until it is accepted.
REQ-025 SHALL ignore sck edges while in IDLE with no frame start.

Reset
REQ-026 SHALL, while areset=1, set the state to IDLE, clear the shift register, bit counter and CRC, and drive m_axis_tdata=0, m_axis_tvalid=0, m_axis_tuser=0, overrun_cnt=0 and frame_err=0.
REQ-027 SHALL preset the synchronizer flops to 0 on reset, so that a frame in flight at reset release is not started until the next genuine fsync 0->1 transition.

Configuration
REQ-028 SHALL, with macro ADS127L01_RX_CRC_EN defined, capture 8 CRC bits after the data and compute CRC-8 (polynomial 0x07, init 0xFF) over the DATA_W data bits; m_axis_tuser=1 when the computed CRC differs from the received CRC; the word is still delivered.
REQ-029 SHALL, without ADS127L01_RX_CRC_EN, have a frame of exactly DATA_W bits, no CRC logic, and m_axis_tuser tied to 0.

Structure
REQ-030 SHALL place the state enum (IDLE/SHIFT/PUSH), the CRC polynomial and init constants, and the crc8_next function in package ads127l01_pkg.
REQ-031 SHALL implement the synchronizer and edge detector as one sub-module, ads127l01_sync_edge, instanced for the sck/dout/fsync group.

Verification
REQ-032 SHALL verify: frame 24'h7FFFFF with tready=1 -> tdata=32'h007FFFFF, one tvalid pulse, 2 aclk cycles after the last sck rising edge.
REQ-033 SHALL verify: frame 24'h800001 -> tdata=32'hFF800001.
REQ-034 SHALL verify: tready=0 across 3 frames -> first word held, overrun_cnt=2; on tready=1 the first word is accepted.
REQ-035 SHALL verify: fsync re-asserted after 10 bits, then a full frame 24'h123456 -> frame_err pulse, then tdata=32'h00123456.
REQ-036 SHALL verify: with CRC enabled, a corrupted CRC byte -> tuser=1; a correct CRC -> tuser=0.
REQ-037 SHALL verify: areset asserted mid-frame, then a full frame 24'h000010 -> all outputs 0 during reset, then tdata=32'h00000010 only.

Source files
------------

// File: rtl/ads127l01_pkg.sv
// ads127l01_pkg: shared receiver state encoding and CRC-8 helpers for the
// ADS127L01 frame-sync receiver.
package ads127l01_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PUSH  = 2'd2
  } rx_state_t;

  localparam int         CRC_W     = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  // One MSB-first step of CRC-8 over a single serial bit.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ads127l01_sync_edge.sv
// ads127l01_sync_edge: brings sck and its companion data lines into the aclk
// domain and flags sck rising edges, keeping data aligned with the edge.
module ads127l01_sync_edge
  import ads127l01_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int WIDTH  = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             sck,
  input  logic [WIDTH-1:0] data,
  output logic             sck_rise,
  output logic [WIDTH-1:0] data_sync
);

  logic [STAGES-1:0] sck_sr;
  logic              sck_d;
  logic [WIDTH-1:0]  data_sr [STAGES];

  // Presetting to 0 means a line already high at reset release looks like a
  // fresh rise, which the fsync history register then qualifies.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sck_sr <= '0;
      sck_d  <= 1'b0;
      for (int i = 0; i < STAGES; i++) data_sr[i] <= '0;
    end else begin
      sck_sr     <= {sck_sr[STAGES-2:0], sck};
      sck_d      <= sck_sr[STAGES-1];
      data_sr[0] <= data;
      for (int i = 1; i < STAGES; i++) data_sr[i] <= data_sr[i-1];
    end
  end

  assign sck_rise  = sck_sr[STAGES-1] & ~sck_d;
  assign data_sync = data_sr[STAGES-1];

endmodule

// File: rtl/ads127l01_fsync_rx.sv
// ads127l01_fsync_rx: ADS127L01 frame-sync master-mode serial receiver with an
// AXI-Stream sample output. Define ADS127L01_RX_CRC_EN to receive and check the CRC-8 byte.
//
// state | meaning
// IDLE  | waiting for an fsync 0->1 frame start with en=1
// SHIFT | capturing frame bits on sck rising edges
// PUSH  | frame complete; present word or count an overrun
module ads127l01_fsync_rx
  import ads127l01_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        en,
  input  logic        sck,
  input  logic        dout,
  input  logic        fsync,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic [15:0] overrun_cnt,
  output logic        frame_err
);

`ifdef ADS127L01_RX_CRC_EN
  localparam int FRAME_BITS = DATA_W + CRC_W;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int               CNT_W     = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_LEFT = CNT_W'(FRAME_BITS - 1);

  rx_state_t                state;
  logic [FRAME_BITS-1:0]    shreg;
  logic [CNT_W-1:0]         bits_left;
  logic                     fsync_prev;
  logic                     sck_rise;
  logic [1:0]               data_sync;
  logic                     dout_s;
  logic                     fsync_s;
  logic                     frame_start;
  logic signed [DATA_W-1:0] word;
  logic [31:0]              word_ext;

  ads127l01_sync_edge #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (2)
  ) u_sync_edge (
    .aclk      (aclk),
    .areset    (areset),
    .sck       (sck),
    .data      ({fsync, dout}),
    .sck_rise  (sck_rise),
    .data_sync (data_sync)
  );

  assign fsync_s     = data_sync[1];
  assign dout_s      = data_sync[0];
  assign frame_start = sck_rise & fsync_s & ~fsync_prev;
  assign word        = shreg[FRAME_BITS-1 -: DATA_W];
  assign word_ext    = 32'(word);

`ifdef ADS127L01_RX_CRC_EN
  logic [7:0] crc;
  logic       crc_err;
  assign crc_err = (crc != shreg[CRC_W-1:0]);
`else
  assign m_axis_tuser = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      shreg         <= '0;
      bits_left     <= '0;
      fsync_prev    <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_cnt   <= '0;
      frame_err     <= 1'b0;
`ifdef ADS127L01_RX_CRC_EN
      crc           <= CRC8_INIT;
      m_axis_tuser  <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (sck_rise) fsync_prev <= fsync_s;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        IDLE, SHIFT: begin
          if (!en) begin
            state <= IDLE;
          end else if (frame_start) begin
            // A start while shifting abandons the partial word.
            frame_err <= (state == SHIFT);
            state     <= SHIFT;
            shreg     <= FRAME_BITS'(dout_s);
            bits_left <= LAST_LEFT;
`ifdef ADS127L01_RX_CRC_EN
            crc       <= crc8_next(CRC8_INIT, dout_s);
`endif
          end else if (state == SHIFT && sck_rise) begin
            shreg     <= {shreg[FRAME_BITS-2:0], dout_s};
            bits_left <= bits_left - CNT_W'(1);
`ifdef ADS127L01_RX_CRC_EN
            if (bits_left > CNT_W'(CRC_W)) crc <= crc8_next(crc, dout_s);
`endif
            if (bits_left == CNT_W'(1)) state <= PUSH;
          end
        end

        PUSH: begin
          state <= IDLE;
          if (!m_axis_tvalid || m_axis_tready) begin
            m_axis_tdata  <= word_ext;
            m_axis_tvalid <= 1'b1;
`ifdef ADS127L01_RX_CRC_EN
            m_axis_tuser  <= crc_err;
`endif
          end else if (overrun_cnt != 16'hFFFF) begin
            overrun_cnt <= overrun_cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads127l01_fsync_rx.sv
// tb_ads127l01_fsync_rx: directed frames into ads127l01_fsync_rx with
// hand-computed expected samples; CRC cases build with ADS127L01_RX_CRC_EN.
module tb_ads127l01_fsync_rx;

  localparam int DATA_W      = 24;
  localparam int SYNC_STAGES = 2;
`ifdef ADS127L01_RX_CRC_EN
  localparam int FB = DATA_W + 8;
`else
  localparam int FB = DATA_W;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        en;
  logic        sck;
  logic        dout;
  logic        fsync;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic [15:0] overrun_cnt;
  logic        frame_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          acc_cnt  = 0;
  int          ferr_cnt = 0;
  logic [31:0] last_data = '0;
  logic        last_user = 1'b0;

  ads127l01_fsync_rx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .en            (en),
    .sck           (sck),
    .dout          (dout),
    .fsync         (fsync),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .overrun_cnt   (overrun_cnt),
    .frame_err     (frame_err)
  );

  always #5 aclk = ~aclk;

  // Inputs change on negedge; sampling 1 time unit later sees the values the
  // next posedge will act on.
  always @(negedge aclk) begin
    #1;
    if (m_axis_tvalid && m_axis_tready) begin
      acc_cnt++;
      last_data = m_axis_tdata;
      last_user = m_axis_tuser;
    end
    if (frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // CRC-8 (x^8+x^2+x+1, init 0xFF) by polynomial long division.
  function automatic logic [7:0] crc8_ref(input logic [23:0] d);
    logic [31:0] r;
    r = {d ^ 24'hFF0000, 8'h00};
    for (int i = 31; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  function automatic logic [FB-1:0] make_frame(input logic [23:0] d, input logic [7:0] crc_flip);
`ifdef ADS127L01_RX_CRC_EN
    return {d, crc8_ref(d) ^ crc_flip};
`else
    return d ^ {16'h0, crc_flip & 8'h00};
`endif
  endfunction

  // One sck period, 8 aclk cycles (sck = aclk/8); fsync marks the frame MSB.
  task automatic send_bit(input logic b, input logic fs);
    sck = 1'b0; dout = b; fsync = fs;
    repeat (4) @(negedge aclk);
    sck = 1'b1;
    repeat (4) @(negedge aclk);
  endtask

  task automatic send_range(input logic [FB-1:0] v, input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_bit(v[FB-1-i], (i == 0));
  endtask

  task automatic send_frame(input logic [23:0] d);
    send_range(make_frame(d, 8'h00), 0, FB);
  endtask

  task automatic idle(input int n);
    sck = 1'b0; fsync = 1'b0;
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    logic [FB-1:0] v;
    int a0;

    areset = 1'b1; en = 1'b1; sck = 1'b0; dout = 1'b0; fsync = 1'b0;
    m_axis_tready = 1'b1;
    repeat (4) @(negedge aclk);
    check("rst_tdata",  m_axis_tdata,  32'h0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("rst_tuser",  32'(m_axis_tuser),  32'h0);
    check("rst_overrun", 32'(overrun_cnt),  32'h0);
    check("rst_frame_err", 32'(frame_err),  32'h0);
    areset = 1'b0;
    idle(4);

    // Positive full-scale; valid exactly SYNC_STAGES+2 posedges after the
    // last sck rise is driven (sync stages, then 2 cycles to present).
    a0 = acc_cnt;
    v = make_frame(24'h7FFFFF, 8'h00);
    send_range(v, 0, FB - 1);
    sck = 1'b0; dout = v[0]; fsync = 1'b0;
    repeat (4) @(negedge aclk);
    sck = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge aclk);
    check("lat_early_tvalid", 32'(m_axis_tvalid), 32'h0);
    @(negedge aclk);
    check("lat_tvalid", 32'(m_axis_tvalid), 32'h1);
    check("pos_tdata",  m_axis_tdata, 32'h007FFFFF);
    check("pos_tuser",  32'(m_axis_tuser), 32'h0);
    @(negedge aclk);
    check("pos_one_pulse", 32'(m_axis_tvalid), 32'h0);
    idle(4);
    check("pos_accepts", 32'(acc_cnt - a0), 32'd1);

    // Negative value sign-extends.
    send_frame(24'h800001);
    idle(4);
    check("neg_tdata", last_data, 32'hFF800001);

    // Back-pressure: first word held, two later words dropped.
    m_axis_tready = 1'b0;
    send_frame(24'h111111);
    send_frame(24'h222222);
    send_frame(24'h333333);
    idle(4);
    check("ovr_held_tdata",  m_axis_tdata, 32'h00111111);
    check("ovr_held_tvalid", 32'(m_axis_tvalid), 32'h1);
    check("ovr_count", 32'(overrun_cnt), 32'd2);
    a0 = acc_cnt;
    m_axis_tready = 1'b1;
    idle(3);
    check("ovr_accept_cnt",  32'(acc_cnt - a0), 32'd1);
    check("ovr_accept_data", last_data, 32'h00111111);
    check("ovr_drained",     32'(m_axis_tvalid), 32'h0);

    // Short frame aborted by a new fsync after 10 bits.
    a0 = ferr_cnt;
    send_range(make_frame(24'hFFFFFF, 8'h00), 0, 10);
    send_frame(24'h123456);
    idle(4);
    check("abort_ferr_cycles", 32'(ferr_cnt - a0), 32'd1);
    check("abort_tdata", last_data, 32'h00123456);

    // Receiver disabled: frame ignored.
    a0 = acc_cnt;
    en = 1'b0;
    send_frame(24'h0F0F0F);
    idle(4);
    check("dis_no_accept", 32'(acc_cnt - a0), 32'd0);
    check("dis_tvalid", 32'(m_axis_tvalid), 32'h0);
    en = 1'b1;

    // Reset mid-frame with a held word and nonzero overrun count.
    m_axis_tready = 1'b0;
    send_frame(24'h0000AA);
    v = make_frame(24'hABCDEF, 8'h00);
    send_range(v, 0, 12);
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    check("mid_rst_tdata",   m_axis_tdata, 32'h0);
    check("mid_rst_tvalid",  32'(m_axis_tvalid), 32'h0);
    check("mid_rst_overrun", 32'(overrun_cnt), 32'h0);
    check("mid_rst_ferr",    32'(frame_err), 32'h0);
    areset = 1'b0;
    m_axis_tready = 1'b1;
    a0 = acc_cnt;
    send_range(v, 12, FB);
    idle(4);
    check("mid_rst_tail_ignored", 32'(acc_cnt - a0), 32'd0);
    send_frame(24'h000010);
    idle(4);
    check("mid_rst_accepts", 32'(acc_cnt - a0), 32'd1);
    check("mid_rst_tdata_after", last_data, 32'h00000010);

`ifdef ADS127L01_RX_CRC_EN
    send_frame(24'h5A5A5A);
    idle(4);
    check("crc_good_tdata", last_data, 32'h005A5A5A);
    check("crc_good_tuser", 32'(last_user), 32'h0);
    send_range(make_frame(24'h5A5A5A, 8'h01), 0, FB);
    idle(4);
    check("crc_bad_tdata", last_data, 32'h005A5A5A);
    check("crc_bad_tuser", 32'(last_user), 32'h1);
`else
    check("nocrc_tuser", 32'(last_user), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
